// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the 64Kx32 data memory among ex, accel and cpu.
// Define ARB_ROUND_ROBIN_EN for rotating priority (default: fixed ex > accel > cpu).
module mem_arbiter #(
    parameter int BURST_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ex_req,
    input  logic                    ex_wrt_en,
    input  logic [15:0]             ex_addr,
    input  logic [31:0]             ex_wrt_data,
    output logic                    ex_gnt,
    output logic                    ex_rd_valid,
    input  logic                    accel_req,
    input  logic                    accel_wrt_en,
    input  logic [15:0]             accel_addr,
    input  logic [31:0]             accel_wrt_data,
    output logic                    accel_gnt,
    output logic                    accel_rd_valid,
    output logic [32*BURST_LEN-1:0] accel_rd_data,
    input  logic                    cpu_req,
    input  logic                    cpu_wrt_en,
    input  logic [15:0]             cpu_addr,
    input  logic [31:0]             cpu_wrt_data,
    output logic                    cpu_gnt,
    output logic                    cpu_rd_valid,
    output logic [31:0]             rd_data,
    output logic                    mem_en,
    output logic                    mem_wrt_en,
    output logic [15:0]             mem_addr,
    output logic [31:0]             mem_wrt_data,
    input  logic [31:0]             mem_rd_data
);

    // BURST_LEN must be a power of two >= 2: bursts are aligned on it.
    localparam int IW = $clog2(BURST_LEN);

    typedef enum logic [1:0] {IDLE, ISSUE, BURST, DRAIN} state_t;

    localparam logic [1:0] SRC_EX    = 2'd0;
    localparam logic [1:0] SRC_ACCEL = 2'd1;
    localparam logic [1:0] SRC_CPU   = 2'd2;

    state_t        state;
    logic [1:0]    cur_src;
    logic          win_v;
    logic [1:0]    win_src;
    logic          sel_we;
    logic [15:0]   sel_addr;
    logic [31:0]   sel_data;
    logic          cap_v;
    logic [1:0]    cap_src;
    logic [IW-1:0] cap_idx;

    assign win_v = ex_req | accel_req | cpu_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] last_src;

    // Rotating priority: the requester after the last winner goes first
    always_comb begin
        win_src = SRC_EX;
        unique case (last_src)
            SRC_EX: begin
                if (accel_req)    win_src = SRC_ACCEL;
                else if (cpu_req) win_src = SRC_CPU;
                else              win_src = SRC_EX;
            end
            SRC_ACCEL: begin
                if (cpu_req)        win_src = SRC_CPU;
                else if (ex_req)    win_src = SRC_EX;
                else                win_src = SRC_ACCEL;
            end
            default: begin
                if (ex_req)         win_src = SRC_EX;
                else if (accel_req) win_src = SRC_ACCEL;
                else                win_src = SRC_CPU;
            end
        endcase
    end

    // Remember the last winner; reset value makes ex highest first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_src <= SRC_CPU;
        end else if (state == IDLE && win_v) begin
            last_src <= win_src;
        end
    end
`else
    // Fixed priority: ex > accel > cpu
    always_comb begin
        win_src = SRC_CPU;
        priority case (1'b1)
            ex_req:    win_src = SRC_EX;
            accel_req: win_src = SRC_ACCEL;
            default:   win_src = SRC_CPU;
        endcase
    end
`endif

    // Route the winner's request fields toward the memory port
    always_comb begin
        sel_we   = cpu_wrt_en;
        sel_addr = cpu_addr;
        sel_data = cpu_wrt_data;
        unique case (win_src)
            SRC_EX: begin
                sel_we   = ex_wrt_en;
                sel_addr = ex_addr;
                sel_data = ex_wrt_data;
            end
            SRC_ACCEL: begin
                sel_we   = accel_wrt_en;
                sel_addr = accel_addr;
                sel_data = accel_wrt_data;
            end
            default: ;
        endcase
    end

    // Arbitration FSM driving grants and the memory strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur_src      <= SRC_EX;
            ex_gnt       <= 1'b0;
            accel_gnt    <= 1'b0;
            cpu_gnt      <= 1'b0;
            mem_en       <= 1'b0;
            mem_wrt_en   <= 1'b0;
            mem_addr     <= '0;
            mem_wrt_data <= '0;
        end else begin
            ex_gnt    <= 1'b0;
            accel_gnt <= 1'b0;
            cpu_gnt   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (win_v) begin
                        cur_src      <= win_src;
                        ex_gnt       <= (win_src == SRC_EX);
                        accel_gnt    <= (win_src == SRC_ACCEL);
                        cpu_gnt      <= (win_src == SRC_CPU);
                        mem_en       <= 1'b1;
                        mem_wrt_en   <= sel_we;
                        mem_wrt_data <= sel_data;
                        if (win_src == SRC_ACCEL && !sel_we) begin
                            mem_addr <= {sel_addr[15:IW], {IW{1'b0}}};
                            state    <= BURST;
                        end else begin
                            mem_addr <= sel_addr;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mem_en     <= 1'b0;
                    mem_wrt_en <= 1'b0;
                    state      <= IDLE;
                end
                BURST: begin
                    // Aligned base: low bits of the address count the beat
                    if (mem_addr[IW-1:0] == IW'(BURST_LEN - 1)) begin
                        mem_en <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        mem_addr <= mem_addr + 16'd1;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read return: tag each read strobe, capture its data one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_v          <= 1'b0;
            cap_src        <= SRC_EX;
            cap_idx        <= '0;
            rd_data        <= '0;
            accel_rd_data  <= '0;
            ex_rd_valid    <= 1'b0;
            accel_rd_valid <= 1'b0;
            cpu_rd_valid   <= 1'b0;
        end else begin
            cap_v          <= mem_en & ~mem_wrt_en;
            cap_src        <= cur_src;
            cap_idx        <= mem_addr[IW-1:0];
            ex_rd_valid    <= 1'b0;
            accel_rd_valid <= 1'b0;
            cpu_rd_valid   <= 1'b0;
            if (cap_v) begin
                if (cap_src == SRC_ACCEL) begin
                    accel_rd_data[32*cap_idx +: 32] <= mem_rd_data;
                    accel_rd_valid <= (cap_idx == IW'(BURST_LEN - 1));
                end else begin
                    rd_data      <= mem_rd_data;
                    ex_rd_valid  <= (cap_src == SRC_EX);
                    cpu_rd_valid <= (cap_src == SRC_CPU);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed burst/reset sequences and random
// request groups checked against a transaction-level arbiter model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int BL = 16;

    logic clk;
    logic rst_n;
    logic ex_req, ex_wrt_en, accel_req, accel_wrt_en, cpu_req, cpu_wrt_en;
    logic [15:0] ex_addr, accel_addr, cpu_addr;
    logic [31:0] ex_wrt_data, accel_wrt_data, cpu_wrt_data;
    logic ex_gnt, ex_rd_valid, accel_gnt, accel_rd_valid, cpu_gnt, cpu_rd_valid;
    logic [32*BL-1:0] accel_rd_data;
    logic [31:0] rd_data;
    logic mem_en, mem_wrt_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_wrt_data, mem_rd_data;

    mem_arbiter #(.BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_req(ex_req), .ex_wrt_en(ex_wrt_en), .ex_addr(ex_addr),
        .ex_wrt_data(ex_wrt_data), .ex_gnt(ex_gnt), .ex_rd_valid(ex_rd_valid),
        .accel_req(accel_req), .accel_wrt_en(accel_wrt_en),
        .accel_addr(accel_addr), .accel_wrt_data(accel_wrt_data),
        .accel_gnt(accel_gnt), .accel_rd_valid(accel_rd_valid),
        .accel_rd_data(accel_rd_data),
        .cpu_req(cpu_req), .cpu_wrt_en(cpu_wrt_en), .cpu_addr(cpu_addr),
        .cpu_wrt_data(cpu_wrt_data), .cpu_gnt(cpu_gnt),
        .cpu_rd_valid(cpu_rd_valid), .rd_data(rd_data),
        .mem_en(mem_en), .mem_wrt_en(mem_wrt_en), .mem_addr(mem_addr),
        .mem_wrt_data(mem_wrt_data), .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Data-memory macro: synchronous, one-cycle read latency
    logic [31:0] mem_a [int];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wrt_en) mem_a[int'(mem_addr)] = mem_wrt_data;
            else mem_rd_data <= mem_a.exists(int'(mem_addr)) ?
                                mem_a[int'(mem_addr)] : 32'h0;
        end
    end

    logic [2:0] gnt_v, val_v;
    assign gnt_v = {cpu_gnt, accel_gnt, ex_gnt};
    assign val_v = {cpu_rd_valid, accel_rd_valid, ex_rd_valid};

    int errors, checks;

    // Reference model: memory contents and last winner (0 ex, 1 accel, 2 cpu)
    logic [31:0] mm [int];
    int rr_last;

    function automatic logic [31:0] mread(int a);
        return mm.exists(a) ? mm[a] : 32'h0;
    endfunction

    function automatic int pick(logic [2:0] rem, int last);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 3; k++)
            if (rem[(last + k) % 3]) return (last + k) % 3;
`else
        for (int k = 0; k < 3; k++)
            if (rem[k]) return k;
`endif
        return -1;
    endfunction

    bit          g_we   [3];
    logic [15:0] g_addr [3];
    logic [31:0] g_data [3];
    logic [31:0] last_rd;

    task automatic set_req(input int i, input bit v, input bit we,
                           input logic [15:0] a, input logic [31:0] d);
        case (i)
            0: begin ex_req = v; ex_wrt_en = we; ex_addr = a; ex_wrt_data = d; end
            1: begin accel_req = v; accel_wrt_en = we; accel_addr = a; accel_wrt_data = d; end
            default: begin cpu_req = v; cpu_wrt_en = we; cpu_addr = a; cpu_wrt_data = d; end
        endcase
    endtask

    function automatic logic [15:0] exp_addr(int w);
        if (w == 1 && !g_we[1]) return {g_addr[1][15:4], 4'h0};
        return g_addr[w];
    endfunction

    function automatic bit outs_zero();
        return gnt_v == 3'b0 && val_v == 3'b0 && !mem_en && !mem_wrt_en &&
               rd_data == 32'h0 && accel_rd_data == '0 &&
               mem_addr == 16'h0 && mem_wrt_data == 32'h0;
    endfunction

    task automatic chk_zero(input string nm);
        checks++;
        if (!outs_zero()) begin
            errors++;
            $display("FAIL %s: gnt=%b val=%b en=%b we=%b addr=%h wd=%h rd=%h line_nz=%b, required all 0",
                     nm, gnt_v, val_v, mem_en, mem_wrt_en, mem_addr, mem_wrt_data,
                     rd_data, |accel_rd_data);
        end
    endtask

    // Raise every requester in act at once (call at a negedge) and check
    // grant order, grant cycles, memory strobes and returned read data.
    task automatic run_group(input logic [2:0] act);
        logic [2:0] rem, pend;
        int next_g, w, budget;
        int exp_c [3];
        logic [31:0] exp_d [3];
        logic [32*BL-1:0] exp_line;
        int base;
        rem = act;
        pend = 3'b0;
        exp_line = '0;
        for (int i = 0; i < 3; i++) begin
            exp_c[i] = 0;
            exp_d[i] = 32'h0;
            if (act[i]) set_req(i, 1'b1, g_we[i], g_addr[i], g_data[i]);
        end
        next_g = cyc + 1;
        budget = 0;
        while ((rem != 3'b0 || pend != 3'b0) && budget < 120) begin
            @(negedge clk);
            budget++;
            if (gnt_v != 3'b0) begin
                w = pick(rem, rr_last);
                checks++;
                if (w < 0) begin
                    errors++;
                    $display("FAIL grant: gnt=%b with nothing pending", gnt_v);
                end else begin
                    if (gnt_v != 3'(1 << w) || cyc != next_g || !mem_en ||
                        mem_wrt_en != g_we[w] || mem_addr != exp_addr(w) ||
                        (g_we[w] && mem_wrt_data != g_data[w])) begin
                        errors++;
                        $display("FAIL grant: gnt=%b cyc=%0d en=%b we=%b addr=%h wd=%h, required gnt=%b cyc=%0d we=%b addr=%h wd=%h",
                                 gnt_v, cyc, mem_en, mem_wrt_en, mem_addr, mem_wrt_data,
                                 3'(1 << w), next_g, g_we[w], exp_addr(w), g_data[w]);
                    end
                    set_req(w, 1'b0, g_we[w], g_addr[w], g_data[w]);
                    rem[w] = 1'b0;
                    rr_last = w;
                    if (g_we[w]) begin
                        mm[int'(g_addr[w])] = g_data[w];
                        next_g = cyc + 2;
                    end else if (w == 1) begin
                        base = int'({g_addr[1][15:4], 4'h0});
                        for (int i = 0; i < BL; i++)
                            exp_line[32*i +: 32] = mread(base + i);
                        exp_c[1] = cyc + 17;
                        next_g = cyc + 18;
                        pend[1] = 1'b1;
                    end else begin
                        exp_d[w] = mread(int'(g_addr[w]));
                        exp_c[w] = cyc + 2;
                        next_g = cyc + 2;
                        pend[w] = 1'b1;
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (val_v[i]) begin
                    checks++;
                    if (i == 1) begin
                        if (!pend[1] || cyc != exp_c[1] || accel_rd_data != exp_line) begin
                            errors++;
                            $display("FAIL burst_line: cyc=%0d line=%h, required cyc=%0d line=%h",
                                     cyc, accel_rd_data, exp_c[1], exp_line);
                        end
                    end else begin
                        last_rd = rd_data;
                        if (!pend[i] || cyc != exp_c[i] || rd_data != exp_d[i]) begin
                            errors++;
                            $display("FAIL rd_return[%0d]: cyc=%0d data=%h, required cyc=%0d data=%h",
                                     i, cyc, rd_data, exp_c[i], exp_d[i]);
                        end
                    end
                    pend[i] = 1'b0;
                end else if (pend[i] && cyc > exp_c[i]) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_missing[%0d]: no valid by cyc=%0d, required at %0d",
                             i, cyc, exp_c[i]);
                    pend[i] = 1'b0;
                end
            end
        end
        if (budget >= 120) begin
            checks++;
            errors++;
            $display("FAIL group_timeout: rem=%b pend=%b, required both 0", rem, pend);
        end
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 16'h0, 32'h0);
        repeat (2) @(negedge clk);
    endtask

    // Wait (bounded) for accel_gnt; returns its cycle or -1
    task automatic wait_accel_gnt(output int t0);
        t0 = -1;
        for (int n = 0; n < 10 && t0 < 0; n++) begin
            @(negedge clk);
            if (accel_gnt) t0 = cyc;
        end
        checks++;
        if (t0 < 0) begin
            errors++;
            $display("FAIL accel_gnt_wait: no grant, required within 10 cycles");
        end
    endtask

    typedef struct {
        int          src;
        bit          we;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, cpu_g, cpu_v, acc_v, nv, n, budget, w, next_g, k;
        bit ok_addr;
        logic [31:0] cpu_d;
        logic [32*BL-1:0] line, exp_line;
        logic [2:0] act;

        errors = 0;
        checks = 0;
        rr_last = 2;
        last_rd = 32'h0;
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 16'h0, 32'h0);
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle_after_reset");

        vt[0] = '{0, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0};
        vt[1] = '{2, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF};
        vt[2] = '{1, 1'b1, 16'h0020, 32'h12345678, 32'h0};
        vt[3] = '{0, 1'b0, 16'h0020, 32'h0,        32'h12345678};
        vt[4] = '{2, 1'b1, 16'hFFFF, 32'hA5A55A5A, 32'h0};
        vt[5] = '{2, 1'b0, 16'hFFFF, 32'h0,        32'hA5A55A5A};
        vt[6] = '{0, 1'b0, 16'h0400, 32'h0,        32'h0};
        for (int i = 0; i < 7; i++) begin
            g_we[vt[i].src] = vt[i].we;
            g_addr[vt[i].src] = vt[i].addr;
            g_data[vt[i].src] = vt[i].data;
            last_rd = 32'hFFFF_0000;
            run_group(3'(1 << vt[i].src));
            if (!vt[i].we) begin
                checks++;
                if (last_rd != vt[i].exp) begin
                    errors++;
                    $display("FAIL vector[%0d]: rd_data=%h, required %h", i, last_rd, vt[i].exp);
                end
            end
        end

        // Simultaneous requests from all three
        g_we[0] = 1'b1; g_addr[0] = 16'h0030; g_data[0] = 32'h11111111;
        g_we[1] = 1'b1; g_addr[1] = 16'h0031; g_data[1] = 32'h22222222;
        g_we[2] = 1'b0; g_addr[2] = 16'h0030; g_data[2] = 32'h0;
        run_group(3'b111);

        // Preload the burst line: mem[0x0120+i] = i
        for (int i = 0; i < BL; i++) begin
            g_we[0] = 1'b1;
            g_addr[0] = 16'h0120 + 16'(i);
            g_data[0] = 32'(i);
            run_group(3'b001);
        end

        // Burst from unaligned address, cpu request raised at T+3
        set_req(1, 1'b1, 1'b0, 16'h012F, 32'h0);
        wait_accel_gnt(t0);
        set_req(1, 1'b0, 1'b0, 16'h012F, 32'h0);
        if (t0 >= 0) begin
            rr_last = 1;
            for (int i = 0; i < BL; i++) exp_line[32*i +: 32] = mread(16'h0120 + i);
            ok_addr = 1'b1;
            cpu_g = -1; cpu_v = -1; acc_v = -1; nv = 0;
            cpu_d = 32'h0; line = '0;
            while (cyc <= t0 + 24) begin
                k = cyc - t0;
                if (k >= 0 && k < BL)
                    if (!mem_en || mem_wrt_en || mem_addr != 16'h0120 + 16'(k)) ok_addr = 1'b0;
                if (k == 3) set_req(2, 1'b1, 1'b0, 16'h0121, 32'h0);
                if (accel_rd_valid) begin acc_v = cyc; nv++; line = accel_rd_data; end
                if (cpu_gnt && cpu_g < 0) begin
                    cpu_g = cyc;
                    set_req(2, 1'b0, 1'b0, 16'h0121, 32'h0);
                    rr_last = 2;
                end
                if (cpu_rd_valid) begin cpu_v = cyc; cpu_d = rd_data; end
                @(negedge clk);
            end
            checks++;
            if (!ok_addr) begin
                errors++;
                $display("FAIL burst_addr: strobe/address sequence wrong, required 0120..012F on T..T+15");
            end
            checks++;
            if (acc_v != t0 + 17 || nv != 1 || line != exp_line) begin
                errors++;
                $display("FAIL burst_valid: cyc=%0d count=%0d line=%h, required cyc=%0d count=1 line=%h",
                         acc_v, nv, line, t0 + 17, exp_line);
            end
            checks++;
            if (cpu_g != t0 + 18) begin
                errors++;
                $display("FAIL cpu_after_burst: gnt cyc=%0d, required %0d", cpu_g, t0 + 18);
            end
            checks++;
            if (cpu_v != t0 + 20 || cpu_d != 32'h1) begin
                errors++;
                $display("FAIL cpu_rd_after_burst: cyc=%0d data=%h, required cyc=%0d data=00000001",
                         cpu_v, cpu_d, t0 + 20);
            end
        end

        // Reset in the middle of a burst
        set_req(1, 1'b1, 1'b0, 16'h0105, 32'h0);
        wait_accel_gnt(t0);
        set_req(1, 1'b0, 1'b0, 16'h0105, 32'h0);
        if (t0 >= 0) begin
            while (cyc < t0 + 8) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk_zero("reset_mid_burst");
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            rr_last = 2;
            nv = 0;
            repeat (25) begin
                @(negedge clk);
                if (accel_rd_valid || mem_en) nv++;
            end
            checks++;
            if (nv != 0) begin
                errors++;
                $display("FAIL aborted_burst: %0d cycles with valid/strobe, required 0", nv);
            end
        end

        // All three requesters held for six grants
        for (int i = 0; i < 3; i++) begin
            g_we[i] = 1'b1;
            g_addr[i] = 16'h0200 + 16'(i);
            g_data[i] = 32'h6000_0000 + 32'(i);
            set_req(i, 1'b1, 1'b1, g_addr[i], g_data[i]);
        end
        next_g = cyc + 1;
        n = 0;
        budget = 0;
        while (n < 6 && budget < 60) begin
            @(negedge clk);
            budget++;
            if (gnt_v != 3'b0) begin
                w = pick(3'b111, rr_last);
                checks++;
                if (gnt_v != 3'(1 << w) || cyc != next_g) begin
                    errors++;
                    $display("FAIL held_grant[%0d]: gnt=%b cyc=%0d, required gnt=%b cyc=%0d",
                             n, gnt_v, cyc, 3'(1 << w), next_g);
                end
                mm[int'(g_addr[w])] = g_data[w];
                rr_last = w;
                next_g = cyc + 2;
                n++;
            end
        end
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 16'h0, 32'h0);
        if (n < 6) begin
            checks++;
            errors++;
            $display("FAIL held_timeout: %0d grants, required 6", n);
        end
        repeat (2) @(negedge clk);

        // Random request groups against the model
        for (int r = 0; r < 30; r++) begin
            act = 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++) begin
                g_we[i] = 1'($urandom_range(0, 1));
                g_addr[i] = 16'h0100 + 16'($urandom_range(0, 63));
                g_data[i] = $urandom;
            end
            run_group(act);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
